interleaver_sched: RTL



---
 rtl/dnn_sched_pkg.sv | 18 +
 rtl/interleaver_sched_if.sv | 22 ++
 rtl/interleaver_sched_out_stage.sv | 34 +++
 rtl/interleaver_sched.sv | 126 ++++++++++++
 4 files changed

// File: rtl/dnn_sched_pkg.sv
// Shared types and width helpers for the datapath sequencers.
package dnn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sched_state_e;

  function automatic int calc_cw(input int fo, input int p, input int z);
    return $clog2(fo * p / z);
  endfunction

  function automatic int calc_aw(input int p, input int z);
    return $clog2(p) * z;
  endfunction

endpackage

// File: rtl/interleaver_sched_if.sv
// Output beat bus from the junction sequencer toward the actmem read logic.
interface interleaver_sched_if #(
  parameter int CW = 3,
  parameter int AW = 40
);
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_mem_idx;
  logic [CW-1:0] out_cycle;
  logic          out_sweep_end;
  logic          out_last;

  modport master (
    output out_valid, out_mem_idx, out_cycle, out_sweep_end, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_mem_idx, out_cycle, out_sweep_end, out_last,
    output out_ready
  );
endinterface

// File: rtl/interleaver_sched_out_stage.sv
// Valid/ready output register: loads on request, holds payload while stalled.
module sched_out_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         ready_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic         can_load_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign can_load_o = !valid_q || ready_i;
  assign valid_o    = valid_q;
  assign data_o     = data_q;

endmodule

// File: rtl/interleaver_sched.sv
// Junction-pass sequencer for interleaver_set; optional backward order via DNN_SCHED_REVERSE_EN.
module interleaver_sched
  import dnn_sched_pkg::*;
#(
  parameter int fo = 2,
  parameter int p  = 32,
  parameter int z  = 8,
  localparam int CW = calc_cw(fo, p, z),
  localparam int AW = calc_aw(p, z)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
`ifdef DNN_SCHED_REVERSE_EN
  input  logic          dir,
`endif
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycle_index,
  input  logic [AW-1:0] mem_idx_in,
  interleaver_sched_if.master out_bus
);

  localparam int SW = $clog2(p / z);
  localparam int PW = AW + CW + 2;

  sched_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic          rev;
  logic [CW-1:0] cnt_init;
  logic [CW-1:0] cnt_step;
  logic          at_end;
  logic          sweep_end;
  logic          can_load;
  logic          advance;
  logic          out_valid;
  logic [PW-1:0] payload_d;
  logic [PW-1:0] payload_q;

`ifdef DNN_SCHED_REVERSE_EN
  logic dir_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      dir_q <= dir;
    end
  end

  assign rev      = dir_q;
  assign cnt_init = dir ? '1 : '0;
`else
  assign rev      = 1'b0;
  assign cnt_init = '0;
`endif

  assign at_end    = rev ? (cnt_q == '0) : (cnt_q == '1);
  assign sweep_end = rev ? (cnt_q[SW-1:0] == '0) : (cnt_q[SW-1:0] == '1);
  assign cnt_step  = rev ? (cnt_q - CW'(1)) : (cnt_q + CW'(1));
  assign advance   = (state_q == RUN) && can_load;
  assign payload_d = {mem_idx_in, cnt_q, sweep_end, at_end};

  // DRAIN spans the acceptance of the last beat plus the done cycle, so a
  // start coinciding with done still lands outside IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            cnt_q   <= cnt_init;
          end
        end
        RUN: begin
          if (advance) begin
            if (at_end) begin
              cnt_q   <= '0;
              state_q <= DRAIN;
            end else begin
              cnt_q <= cnt_step;
            end
          end
        end
        DRAIN: begin
          if (done_q) begin
            state_q <= IDLE;
          end else if (out_valid && out_bus.out_ready) begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sched_out_stage #(
    .W (PW)
  ) u_out_stage (
    .clk        (clk),
    .reset      (reset),
    .load_i     (advance),
    .ready_i    (out_bus.out_ready),
    .data_i     (payload_d),
    .valid_o    (out_valid),
    .can_load_o (can_load),
    .data_o     (payload_q)
  );

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign cycle_index = cnt_q;

  assign out_bus.out_valid     = out_valid;
  assign out_bus.out_mem_idx   = payload_q[PW-1 -: AW];
  assign out_bus.out_cycle     = payload_q[CW+1 : 2];
  assign out_bus.out_sweep_end = payload_q[1];
  assign out_bus.out_last      = payload_q[0];

endmodule
